// File: rtl/gf_lsb_serial_mult.sv
// rtl/gf_lsb_serial_mult.sv - bit-serial GF(2^M) multiplier, b scanned LSB-first, valid/ready on both sides
module gf_lsb_serial_mult #(
    parameter int M = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [M:1] a,
    input  logic [M:1] b,
    input  logic [M:1] g,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [M:1] c
);

    localparam int CW = $clog2(M);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [M:1]    a_r;
    logic [M:1]    b_r;
    logic [M:1]    g_r;
    logic [M:1]    c_r;
    logic [M-1:0]  b_vec;
    logic          b_bit;
    logic          last_step;
    logic [M:1]    a_next;

    assign b_vec     = b_r;
    assign b_bit     = b_vec[cnt];
    assign last_step = (cnt == CW'(M - 1));
    // a_r is multiplied by x and reduced every step, so it never grows past degree M-1
    assign a_next    = {a_r[M-1:1], 1'b0} ^ (a_r[M] ? g_r : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            a_r <= '0;
            b_r <= '0;
            g_r <= '0;
            c_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r <= a;
                        b_r <= b;
                        g_r <= g;
                        c_r <= '0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    if (b_bit) begin
                        c_r <= c_r ^ a_r;
                    end
                    a_r <= a_next;
                    cnt <= last_step ? '0 : cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign c = c_r;

endmodule

// File: tb/tb_gf_lsb_serial_mult.sv
// tb/tb_gf_lsb_serial_mult.sv - scoreboard bench for gf_lsb_serial_mult (M=8 and M=4)
module tb_gf_lsb_serial_mult;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [8:1] a, b, g, c;
    logic       in_valid4, in_ready4, out_valid4, out_ready4;
    logic [4:1] a4, b4, g4, c4;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit rand_bp  = 1'b0;

    logic [8:1] exp_q[$];
    int         lat_q[$];

    gf_lsb_serial_mult #(.M(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .g(g), .out_valid(out_valid), .out_ready(out_ready), .c(c)
    );

    gf_lsb_serial_mult #(.M(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .g(g4), .out_valid(out_valid4), .out_ready(out_ready4), .c(c4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Polynomial product followed by long division by x^m + g
    function automatic logic [31:0] gf_ref(input logic [31:0] x, input logic [31:0] y,
                                           input logic [31:0] gp, input int m);
        logic [63:0] p;
        logic [63:0] poly;
        p = '0;
        for (int i = 0; i < m; i++)
            if (y[i]) p = p ^ (64'(x) << i);
        poly = (64'd1 << m) | 64'(gp);
        for (int d = 2 * m - 2; d >= m; d--)
            if (p[d]) p = p ^ (poly << (d - m));
        return p[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send8(input logic [8:1] av, input logic [8:1] bv, input logic [8:1] gv,
                         input logic [8:1] expv);
        int w;
        w = 0;
        a = av; b = bv; g = gv; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            check("send_accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(expv);
        lat_q.push_back(cyc + 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() > 0 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic run4(input logic [4:1] av, input logic [4:1] bv, input logic [4:1] gv);
        int w;
        int t;
        w = 0;
        a4 = av; b4 = bv; g4 = gv; in_valid4 = 1'b1;
        @(negedge clk);
        while (!in_ready4 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("m4_accept", 32'(in_ready4), 32'd1);
        t = cyc + 1;
        @(posedge clk);
        #1 in_valid4 = 1'b0;
        w = 0;
        @(negedge clk);
        while (!out_valid4 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("m4_latency", 32'(cyc - t), 32'd4);
        check("m4_product", 32'(c4), gf_ref(32'(av), 32'(bv), 32'(gv), 4));
        @(negedge clk);
        check("m4_ready_after_hs", 32'(in_ready4), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every output handshake against the scoreboard
    initial begin
        logic prev_ov;
        logic hs_prev;
        logic [8:1] e;
        int t;
        prev_ov = 1'b0;
        hs_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ov = 1'b0;
                hs_prev = 1'b0;
                continue;
            end
            if (hs_prev) check("ready_after_hs", 32'(in_ready), 32'd1);
            if (out_valid && !prev_ov) begin
                if (lat_q.size() == 0) begin
                    check("spurious_valid", 32'(out_valid), 32'd0);
                end else begin
                    t = lat_q.pop_front();
                    check("latency", 32'(cyc - t), 32'd8);
                end
            end
            if (out_valid) check("no_ready_in_done", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("product", 32'(c), 32'(e));
                end
            end
            hs_prev = out_valid && out_ready;
            prev_ov = out_valid;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:1] av, bv, gv;
        int w;
        in_valid = 1'b0; a = '0; b = '0; g = '0; out_ready = 1'b1;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; g4 = '0; out_ready4 = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_c", 32'(c), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        send8(8'h57, 8'h83, 8'h1B, 8'hC1);
        drain();

        send8(8'h02, 8'h80, 8'h1B, 8'h1B);
        send8(8'h57, 8'h13, 8'h1B, 8'hFE);
        send8(8'hA5, 8'h01, 8'h1B, 8'hA5);
        send8(8'hFF, 8'h00, 8'h1B, 8'h00);
        drain();

        // Backpressure: result must hold while out_ready is low
        out_ready = 1'b0;
        send8(8'h57, 8'h83, 8'h1B, 8'hC1);
        w = 0;
        @(negedge clk);
        while (!out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        for (int i = 0; i < 20; i++) begin
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_c", 32'(c), 32'hC1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        // Second operand set presented while busy; accepted only after return to IDLE
        send8(8'h57, 8'h83, 8'h1B, 8'hC1);
        send8(8'hFF, 8'hFF, 8'h1B, 8'(gf_ref(32'hFF, 32'hFF, 32'h1B, 8)));
        drain();

        // Asynchronous reset in the middle of RUN
        send8(8'h57, 8'h83, 8'h1B, 8'hC1);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_c", 32'(c), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        exp_q.delete();
        lat_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("postrst_in_ready", 32'(in_ready), 32'd1);
        check("postrst_out_valid", 32'(out_valid), 32'd0);
        check("postrst_c", 32'(c), 32'd0);
        @(posedge clk);
        #1;
        send8(8'h02, 8'h80, 8'h1B, 8'h1B);
        drain();

        // Random operands and polynomials with random backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 30; i++) begin
            av = 8'($urandom);
            bv = 8'($urandom);
            gv = (i % 2 == 0) ? 8'h1B : 8'($urandom);
            send8(av, bv, gv, 8'(gf_ref(32'(av), 32'(bv), 32'(gv), 8)));
        end
        rand_bp = 1'b0;
        out_ready = 1'b1;
        drain();

        run4(4'h9, 4'h6, 4'h3);
        for (int i = 0; i < 6; i++)
            run4(4'($urandom), 4'($urandom), 4'h3);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
